// File: rtl/comparator_sequential_pkg.sv
// ============================================================================
// comparator_pkg : shared types and mode decoding for comparator_sequential
// Revision: 1.0
// ============================================================================
`default_nettype none

package comparator_pkg;

   typedef enum logic [2:0] {
      CMP_EQ   = 3'd0,
      CMP_NE   = 3'd1,
      CMP_LT   = 3'd2,
      CMP_LE   = 3'd3,
      CMP_GT   = 3'd4,
      CMP_GE   = 3'd5,
      CMP_RSV6 = 3'd6,
      CMP_RSV7 = 3'd7
   } cmp_mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic out;
      logic err;
   } mode_res_t;

   function automatic mode_res_t mode_eval(input logic [2:0] mode,
                                           input logic       eq,
                                           input logic       lt,
                                           input logic       gt);
      mode_res_t r;
      r.out = 1'b0;
      r.err = 1'b0;
      case (mode)
         CMP_EQ:  r.out = eq;
         CMP_NE:  r.out = ~eq;
         CMP_LT:  r.out = lt;
         CMP_LE:  r.out = lt | eq;
         CMP_GT:  r.out = gt;
         CMP_GE:  r.out = gt | eq;
         default: r.err = 1'b1;
      endcase
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/comparator_sequential_if.sv
// ============================================================================
// comparator_sequential_if : start/busy/done request and result bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface comparator_sequential_if #(
   parameter int Nbits = 16
);
   logic             start;
   logic [Nbits-1:0] a_in;
   logic [Nbits-1:0] b_in;
   logic [2:0]       mode;
   logic             is_signed;
   logic             busy;
   logic             done;
   logic             out;
   logic             eq;
   logic             lt;
   logic             gt;
   logic             mode_err;

   modport master (
      output start, a_in, b_in, mode, is_signed,
      input  busy, done, out, eq, lt, gt, mode_err
   );

   modport slave (
      input  start, a_in, b_in, mode, is_signed,
      output busy, done, out, eq, lt, gt, mode_err
   );
endinterface

`default_nettype wire

// File: rtl/comparator_sequential_chunk_compare.sv
// ============================================================================
// chunk_compare : combinational magnitude compare of one operand slice
// Revision: 1.0
// ============================================================================
`default_nettype none

module chunk_compare #(
   parameter int CHUNK = 4
) (
   input  wire logic [CHUNK-1:0] a_chunk,
   input  wire logic [CHUNK-1:0] b_chunk,
   input  wire logic             invert_msb,
   output logic                  differ,
   output logic                  lt
);
   logic [CHUNK-1:0] a_w;
   logic [CHUNK-1:0] b_w;

   // Flipping the sign bit maps two's-complement order onto unsigned order.
   always_comb begin
      a_w            = a_chunk;
      b_w            = b_chunk;
      a_w[CHUNK-1]   = a_chunk[CHUNK-1] ^ invert_msb;
      b_w[CHUNK-1]   = b_chunk[CHUNK-1] ^ invert_msb;
   end

   assign differ = (a_w != b_w);
   assign lt     = (a_w < b_w);

endmodule

`default_nettype wire

// File: rtl/comparator_sequential.sv
// ============================================================================
// comparator_sequential : multi-cycle relational compare, MSB chunk first
// Revision: 1.0
// ============================================================================
`default_nettype none

module comparator_sequential
   import comparator_pkg::*;
#(
   parameter int Nbits = 16,
   parameter int CHUNK = 4
) (
   input  wire logic              clock,
   input  wire logic              reset_n,
   comparator_sequential_if.slave bus
);
   localparam int             NCHUNK  = Nbits / CHUNK;
   localparam int             CW      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0]  CNT_TOP = CW'(NCHUNK - 1);

   state_e           state_q;
   logic [Nbits-1:0] a_q, b_q;
   logic [2:0]       mode_q;
   logic             sgn_q;
   logic [CW-1:0]    cnt_q;
   logic             decided_q, ltr_q;
   logic             busy_q, done_q, out_q, eq_q, lt_q, gt_q, err_q;

   logic [CHUNK-1:0] a_chunk, b_chunk;
   logic             chunk_differ, chunk_lt;
   logic             decided_d, ltr_d;
   mode_res_t        res_d;

   assign a_chunk = a_q[int'(cnt_q)*CHUNK +: CHUNK];
   assign b_chunk = b_q[int'(cnt_q)*CHUNK +: CHUNK];

   chunk_compare #(.CHUNK(CHUNK)) u_chunk (
      .a_chunk    (a_chunk),
      .b_chunk    (b_chunk),
      .invert_msb (sgn_q && (cnt_q == CNT_TOP)),
      .differ     (chunk_differ),
      .lt         (chunk_lt)
   );

   // The first differing chunk (from the top) fixes the ordering.
   always_comb begin
      decided_d = decided_q;
      ltr_d     = ltr_q;
      if (!decided_q && chunk_differ) begin
         decided_d = 1'b1;
         ltr_d     = chunk_lt;
      end
      res_d = mode_eval(mode_q, ~decided_d, decided_d & ltr_d, decided_d & ~ltr_d);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         mode_q    <= '0;
         sgn_q     <= 1'b0;
         cnt_q     <= '0;
         decided_q <= 1'b0;
         ltr_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         out_q     <= 1'b0;
         eq_q      <= 1'b0;
         lt_q      <= 1'b0;
         gt_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (bus.start) begin
                  a_q       <= bus.a_in;
                  b_q       <= bus.b_in;
                  mode_q    <= bus.mode;
                  sgn_q     <= bus.is_signed;
                  cnt_q     <= CNT_TOP;
                  decided_q <= 1'b0;
                  ltr_q     <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= RUN;
               end else begin
                  state_q   <= IDLE;
               end
            end
            RUN: begin
               decided_q <= decided_d;
               ltr_q     <= ltr_d;
               if (cnt_q == '0) begin
                  eq_q    <= ~decided_d;
                  lt_q    <= decided_d & ltr_d;
                  gt_q    <= decided_d & ~ltr_d;
                  out_q   <= res_d.out;
                  err_q   <= res_d.err;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  cnt_q   <= cnt_q - 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.out      = out_q;
   assign bus.eq       = eq_q;
   assign bus.lt       = lt_q;
   assign bus.gt       = gt_q;
   assign bus.mode_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_comparator_sequential.sv
// ============================================================================
// tb_comparator_sequential : directed and grid checks of comparator_sequential
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_comparator_sequential;
   logic clock = 1'b0;
   logic reset_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clock = ~clock;

   // 16-bit, 4-bit chunk instance for directed protocol tests
   comparator_sequential_if #(.Nbits(16)) bif16 ();
   comparator_sequential #(.Nbits(16), .CHUNK(4)) dut16 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bif16)
   );
   logic [4:0] res16;
   assign res16 = {bif16.out, bif16.eq, bif16.lt, bif16.gt, bif16.mode_err};

   // Three 8-bit instances (CHUNK 8, 2, 1) sharing one stimulus
   logic       start8, sgn8;
   logic [7:0] a8, b8;
   logic [2:0] mode8;
   logic [2:0] done8, busy8;
   logic [4:0] res8 [3];
   comparator_sequential_if #(.Nbits(8)) bif8 [3] ();

   for (genvar g_i = 0; g_i < 3; g_i++) begin : g_dut8
      localparam int CH = (g_i == 0) ? 8 : (g_i == 1) ? 2 : 1;
      assign bif8[g_i].start     = start8;
      assign bif8[g_i].a_in      = a8;
      assign bif8[g_i].b_in      = b8;
      assign bif8[g_i].mode      = mode8;
      assign bif8[g_i].is_signed = sgn8;
      assign done8[g_i] = bif8[g_i].done;
      assign busy8[g_i] = bif8[g_i].busy;
      assign res8[g_i]  = {bif8[g_i].out, bif8[g_i].eq, bif8[g_i].lt,
                           bif8[g_i].gt, bif8[g_i].mode_err};
      comparator_sequential #(.Nbits(8), .CHUNK(CH)) dut8 (
         .clock   (clock),
         .reset_n (reset_n),
         .bus     (bif8[g_i])
      );
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: {out, eq, lt, gt, mode_err}
   function automatic logic [4:0] model8(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] m, input logic s);
      logic eq, lt, gt, o, e;
      eq = (a == b);
      lt = s ? ($signed(a) < $signed(b)) : (a < b);
      gt = !eq && !lt;
      e  = 1'b0;
      o  = 1'b0;
      case (m)
         3'd0: o = eq;
         3'd1: o = !eq;
         3'd2: o = lt;
         3'd3: o = lt || eq;
         3'd4: o = gt;
         3'd5: o = gt || eq;
         default: e = 1'b1;
      endcase
      return {o, eq, lt, gt, e};
   endfunction

   task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic [2:0] m,
                        input logic s, input bit scramble, input logic [4:0] exp, input string tag);
      int n = 0;
      int busy_n;
      bit seen = 0;
      bif16.a_in = a; bif16.b_in = b; bif16.mode = m; bif16.is_signed = s;
      bif16.start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bif16.start = 1'b0;
      busy_n = bif16.busy ? 1 : 0;
      while (!seen && n < 20) begin
         @(negedge clock);
         n++;
         if (scramble && n == 1) begin
            bif16.a_in = 16'h0000; bif16.b_in = 16'hFFFF; bif16.mode = 3'd0;
         end
         if (bif16.done) seen = 1;
         else if (bif16.busy) busy_n++;
      end
      check({tag, "_latency"}, seen ? n : -1, 4);
      check({tag, "_busy_cycles"}, busy_n, 4);
      check({tag, "_result"}, res16, exp);
      @(negedge clock);
      check({tag, "_done_pulse"}, {bif16.done, bif16.busy}, 2'b00);
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] m,
                       input logic s, input bit chk_lat);
      logic [4:0] exp;
      logic [4:0] got [3];
      int         lat [3];
      bit   [2:0] seen = '0;
      int         nch [3] = '{1, 4, 8};
      exp = model8(a, b, m, s);
      a8 = a; b8 = b; mode8 = m; sgn8 = s; start8 = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start8 = 1'b0;
      for (int n = 1; n <= 12 && seen != 3'b111; n++) begin
         @(negedge clock);
         for (int i = 0; i < 3; i++) begin
            if (!seen[i] && done8[i]) begin
               seen[i] = 1'b1;
               lat[i]  = n;
               got[i]  = res8[i];
            end
         end
      end
      for (int i = 0; i < 3; i++) begin
         if (!seen[i]) begin
            check($sformatf("done8_timeout[%0d]", i), 0, 1);
         end else begin
            check($sformatf("res8[%0d] a=%h b=%h m=%0d s=%0b", i, a, b, m, s), got[i], exp);
            if (chk_lat) check($sformatf("lat8[%0d]", i), lat[i], nch[i]);
         end
      end
   endtask

   logic [7:0] vals [12] = '{8'h00, 8'h01, 8'h02, 8'h3F, 8'h40, 8'h7E,
                             8'h7F, 8'h80, 8'h81, 8'hC0, 8'hFE, 8'hFF};

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      bit  seen;
      reset_n = 1'b0;
      bif16.start = 1'b0; bif16.a_in = '0; bif16.b_in = '0;
      bif16.mode = '0; bif16.is_signed = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0; mode8 = '0; sgn8 = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      check("reset16", {bif16.busy, bif16.done, res16}, 7'b0);
      check("reset8", {busy8, done8, res8[0], res8[1], res8[2]}, 21'b0);

      run16(16'h1234, 16'h1234, 3'd0, 1'b0, 1'b0, 5'b11000, "eq_basic");
      repeat (3) @(negedge clock);
      check("hold_idle", res16, 5'b11000);
      run16(16'h8000, 16'h7FFF, 3'd2, 1'b1, 1'b0, 5'b10100, "signed_lt");
      run16(16'h8000, 16'h7FFF, 3'd2, 1'b0, 1'b0, 5'b00010, "unsigned_lt");
      run16(16'hF000, 16'h0FFF, 3'd5, 1'b0, 1'b1, 5'b10010, "early_ge");
      run16(16'h00A0, 16'h00A1, 3'd3, 1'b0, 1'b0, 5'b10100, "le_lowchunk");

      // Back-to-back: start held through RUN and DONE
      bif16.a_in = 16'h0005; bif16.b_in = 16'h0003; bif16.mode = 3'd4;
      bif16.is_signed = 1'b0; bif16.start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bif16.a_in = 16'h0009; bif16.b_in = 16'h0002; bif16.mode = 3'd7;
      n = 0; seen = 0;
      while (!seen && n < 20) begin
         @(negedge clock); n++;
         if (bif16.done) seen = 1;
      end
      check("b2b_first_latency", seen ? n : -1, 4);
      check("b2b_first_result", res16, 5'b10010);
      @(negedge clock);
      bif16.start = 1'b0;
      check("b2b_rerun", {bif16.busy, bif16.done}, 2'b10);
      n = 0; seen = 0;
      while (!seen && n < 20) begin
         @(negedge clock); n++;
         if (n == 2) begin
            bif16.start = 1'b1; bif16.a_in = 16'h0000; bif16.b_in = 16'hFFFF; bif16.mode = 3'd0;
         end
         if (n == 3) bif16.start = 1'b0;
         if (bif16.done) seen = 1;
      end
      check("b2b_second_latency", seen ? n : -1, 4);
      check("b2b_second_result", res16, 5'b00011);
      @(negedge clock);
      check("b2b_idle", {bif16.busy, bif16.done}, 2'b00);

      // Reset in the middle of a compare
      bif16.a_in = 16'h0001; bif16.b_in = 16'h0002; bif16.mode = 3'd2; bif16.start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bif16.start = 1'b0;
      @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      check("midrun_reset_outputs", {bif16.busy, bif16.done, res16}, 7'b0);
      seen = 0;
      repeat (6) begin
         @(negedge clock);
         if (bif16.done) seen = 1;
      end
      check("midrun_reset_no_done", seen, 1'b0);

      // Narrow instances: boundary chunk widths with latency checks
      run8(8'h80, 8'h7F, 3'd2, 1'b1, 1'b1);
      run8(8'h80, 8'h7F, 3'd2, 1'b0, 1'b1);
      run8(8'h5A, 8'h5A, 3'd1, 1'b0, 1'b1);

      for (int ia = 0; ia < 12; ia++)
         for (int ib = 0; ib < 12; ib++)
            for (int m = 0; m < 8; m++)
               for (int s = 0; s < 2; s++)
                  run8(vals[ia], vals[ib], 3'(m), 1'(s), 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
